// File: rtl/zedboard_pkg.sv
// Shared constants for the ZedBoard glue: peripheral map, 640x480 VGA timing, GPIO widths.
// The VGA block is built only when ZEDBOARD_VGA_EN is defined.
package zedboard_pkg;

    localparam int unsigned VGA_CLK_DIV    = 5;
    localparam int unsigned GPIO_IN_WIDTH  = 13;
    localparam int unsigned GPIO_OUT_WIDTH = 8;
    localparam int unsigned RST_SWITCH_BIT = 9;

    localparam logic [31:0] PERIPH_BASE   = 32'hF000_0000;
    localparam logic [31:0] OFF_GPIO_OUT  = 32'h0;
    localparam logic [31:0] OFF_GPIO_IN   = 32'h4;
    localparam logic [31:0] OFF_VGA_CTRL  = 32'h8;
    localparam logic [31:0] OFF_VGA_COLOR = 32'hC;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BACK    = 10'd48;
    localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;
    localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_BAR_W   = 10'd80;

    typedef enum logic [2:0] {
        RegCore,
        RegUnmapped,
        RegGpioOut,
        RegGpioIn,
        RegVgaCtrl,
        RegVgaColor
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        if (addr < PERIPH_BASE)                        sel = RegCore;
        else if (addr == PERIPH_BASE + OFF_GPIO_OUT)   sel = RegGpioOut;
        else if (addr == PERIPH_BASE + OFF_GPIO_IN)    sel = RegGpioIn;
        else if (addr == PERIPH_BASE + OFF_VGA_CTRL)   sel = RegVgaCtrl;
        else if (addr == PERIPH_BASE + OFF_VGA_COLOR)  sel = RegVgaColor;
        else                                           sel = RegUnmapped;
        return sel;
    endfunction

endpackage

// File: rtl/top_core.sv
// Stand-in for the RockWave core: fetch PC plus a fixed data-bus program that drives the
// memory-mapped peripherals and writes the last loaded word back out.
module top_core
    import zedboard_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we,
    output logic        dmem_re,
    input  logic [31:0] dmem_rdata
);

    logic [13:0] pc;
    logic        re_q;
    logic [31:0] acc_q;

    top_fetch u_top_fetch (
        .clk             (clk),
        .rst_n           (rst_n),
        .program_counter (pc)
    );

    // Load data returns one clock after the request; latch it for the write-back step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            re_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            re_q <= dmem_re;
            if (re_q) acc_q <= dmem_rdata;
        end
    end

    always_comb begin
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_we    = 1'b0;
        dmem_re    = 1'b0;
        case (pc)
            14'd8:    begin dmem_addr = PERIPH_BASE + OFF_GPIO_OUT; dmem_wdata = 32'hA5; dmem_we = 1'b1; end
            14'd9:    begin dmem_addr = PERIPH_BASE + OFF_GPIO_OUT; dmem_re = 1'b1; end
            14'd12:   begin
                dmem_addr  = PERIPH_BASE + OFF_GPIO_OUT;
                dmem_wdata = 32'h5A;
                dmem_we    = 1'b1;
                dmem_re    = 1'b1;
            end
            14'd14:   begin dmem_addr = PERIPH_BASE + 32'h10; dmem_re = 1'b1; end
            14'd15:   begin dmem_addr = PERIPH_BASE + 32'h10; dmem_wdata = 32'hFF; dmem_we = 1'b1; end
            14'd16:   begin dmem_addr = PERIPH_BASE + OFF_VGA_CTRL; dmem_wdata = 32'h1; dmem_we = 1'b1; end
            14'd17:   begin dmem_addr = PERIPH_BASE + OFF_VGA_CTRL; dmem_re = 1'b1; end
            14'd20:   begin dmem_addr = 32'h0000_0000; dmem_wdata = 32'hFF; dmem_we = 1'b1; end
            14'd40:   begin dmem_addr = PERIPH_BASE + OFF_GPIO_IN; dmem_re = 1'b1; end
            14'd42:   begin dmem_addr = PERIPH_BASE + OFF_GPIO_OUT; dmem_wdata = acc_q; dmem_we = 1'b1; end
            14'd1900: begin dmem_addr = PERIPH_BASE + OFF_VGA_CTRL; dmem_wdata = 32'h0; dmem_we = 1'b1; end
            14'd1901: begin dmem_addr = PERIPH_BASE + OFF_VGA_COLOR; dmem_wdata = 32'hF80; dmem_we = 1'b1; end
            14'd1902: begin dmem_addr = PERIPH_BASE + OFF_VGA_COLOR; dmem_re = 1'b1; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/top_fetch.sv
// Fetch stage of the core stand-in: a 14-bit program counter stepping every clock.
module top_fetch (
    input  logic        clk,
    input  logic        rst_n,
    output logic [13:0] program_counter
);

    always_ff @(posedge clk) begin
        if (!rst_n) program_counter <= '0;
        else        program_counter <= program_counter + 14'd1;
    end

endmodule

// File: rtl/zedboard_vga_timing.sv
// 640x480 timing: pixel-enable divider, h/v counters, raw active-low syncs and active flag.
// Only compiled in when ZEDBOARD_VGA_EN is defined.
`ifdef ZEDBOARD_VGA_EN
module vga_timing
    import zedboard_pkg::*;
#(
    parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hcount,
    output logic       hsync,
    output logic       vsync,
    output logic       active
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DivW-1:0] div_q;
    logic [9:0]      vcount;
    logic            pix_en;

    assign pix_en = (div_q == DivW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            div_q <= pix_en ? '0 : div_q + 1'b1;
            if (pix_en) begin
                if (hcount == H_TOTAL - 10'd1) begin
                    hcount <= '0;
                    vcount <= (vcount == V_TOTAL - 10'd1) ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    assign hsync  = !((hcount >= H_VISIBLE + H_FRONT) && (hcount < H_VISIBLE + H_FRONT + H_SYNC));
    assign vsync  = !((vcount >= V_VISIBLE + V_FRONT) && (vcount < V_VISIBLE + V_FRONT + V_SYNC));
    assign active = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);

endmodule
`endif

// File: rtl/zedboard_top.sv
// ZedBoard top for RockWave: switch-driven reset, GPIO and VGA register decode, colour mux.
// Define ZEDBOARD_VGA_EN to build the VGA generator; otherwise syncs idle high and rgb is 0.
module zedboard_top
    import zedboard_pkg::*;
#(
    parameter int unsigned CLK_DIV    = VGA_CLK_DIV,
    parameter int unsigned GPIO_IN_W  = GPIO_IN_WIDTH,
    parameter int unsigned GPIO_OUT_W = GPIO_OUT_WIDTH,
    parameter int unsigned RST_BIT    = RST_SWITCH_BIT
) (
    input  logic                  clk,
    input  logic [GPIO_IN_W-1:0]  gpio_pin_in,
    output logic [GPIO_OUT_W-1:0] gpio_pin_out,
    output logic                  hsync,
    output logic                  vsync,
    output logic [3:0]            rdata,
    output logic [3:0]            gdata,
    output logic [3:0]            bdata
);

    logic [GPIO_IN_W-1:0]  sync1_q, sync2_q;
    logic                  rst_n;
    logic [31:0]           dmem_addr, dmem_wdata, dmem_rdata, rd_mux, rd_data_q;
    logic                  dmem_we, dmem_re, rd_valid_q;
    logic [GPIO_OUT_W-1:0] gpio_out_q;
    logic                  vga_ctrl;
    logic [11:0]           vga_color;
    reg_sel_e              sel;
    logic                  unused_wdata;

    // The synchronizer is deliberately not reset: it is the source of rst_n.
    always_ff @(posedge clk) begin
        sync1_q <= gpio_pin_in;
        sync2_q <= sync1_q;
    end
    assign rst_n = sync2_q[RST_BIT];

    top_core u_top_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_rdata (dmem_rdata)
    );

    assign sel          = decode_addr(dmem_addr);
    assign unused_wdata = ^dmem_wdata;

    always_comb begin
        rd_mux = '0;
        case (sel)
            RegGpioOut:  rd_mux = 32'(gpio_out_q);
            RegGpioIn:   rd_mux = 32'(sync2_q);
            RegVgaCtrl:  rd_mux = 32'(vga_ctrl);
            RegVgaColor: rd_mux = 32'(vga_color);
            default:     ;
        endcase
    end

    // Read mux sees pre-write register values, so a same-cycle read/write returns old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gpio_out_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= dmem_re && (sel != RegCore);
            rd_data_q  <= rd_mux;
            if (dmem_we && sel == RegGpioOut) gpio_out_q <= dmem_wdata[GPIO_OUT_W-1:0];
        end
    end

    assign dmem_rdata   = rd_data_q;
    assign gpio_pin_out = gpio_out_q;

`ifdef ZEDBOARD_VGA_EN
    logic [9:0]  hcount;
    logic        h_sync_raw, v_sync_raw, active;
    logic [2:0]  bar;
    logic [11:0] pixel, rgb_q;
    logic        hsync_q, vsync_q;

    vga_timing #(
        .CLK_DIV (CLK_DIV)
    ) u_vga_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .hcount (hcount),
        .hsync  (h_sync_raw),
        .vsync  (v_sync_raw),
        .active (active)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_ctrl  <= 1'b0;
            vga_color <= '0;
        end else if (dmem_we) begin
            if (sel == RegVgaCtrl)  vga_ctrl  <= dmem_wdata[0];
            if (sel == RegVgaColor) vga_color <= dmem_wdata[11:0];
        end
    end

    assign bar   = 3'(hcount / H_BAR_W);
    assign pixel = vga_ctrl ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : vga_color;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            hsync_q <= h_sync_raw;
            vsync_q <= v_sync_raw;
            rgb_q   <= active ? pixel : 12'h000;
        end
    end

    assign hsync                 = hsync_q;
    assign vsync                 = vsync_q;
    assign {rdata, gdata, bdata} = rgb_q;
`else
    localparam int unsigned unused_clk_div = CLK_DIV;

    assign vga_ctrl              = 1'b0;
    assign vga_color             = '0;
    assign hsync                 = 1'b1;
    assign vsync                 = 1'b1;
    assign {rdata, gdata, bdata} = 12'h000;
`endif

endmodule

// File: tb/tb_zedboard_top.sv
// Self-checking bench for zedboard_top: scoreboarded bus reads plus cycle-exact GPIO/VGA checks.
module tb_zedboard_top;

`ifdef ZEDBOARD_VGA_EN
    localparam bit VgaEn = 1'b1;
`else
    localparam bit VgaEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic [12:0] gpio_pin_in;
    logic [7:0]  gpio_pin_out;
    logic        hsync, vsync;
    logic [3:0]  rdata, gdata, bdata;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];

    zedboard_top dut (
        .clk          (clk),
        .gpio_pin_in  (gpio_pin_in),
        .gpio_pin_out (gpio_pin_out),
        .hsync        (hsync),
        .vsync        (vsync),
        .rdata        (rdata),
        .gdata        (gdata),
        .bdata        (bdata)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // The stand-in core issues the same six peripheral loads after every reset release.
    task automatic push_reads();
        exp_q.push_back(32'h0000_00A5);
        exp_q.push_back(32'h0000_00A5);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(VgaEn ? 32'h1 : 32'h0);
        exp_q.push_back(32'h0000_1234);
        exp_q.push_back(VgaEn ? 32'hF80 : 32'h0);
    endtask

    always @(negedge clk) begin
        if (dut.rd_valid_q === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected @cyc %0d: got 0x%0h, expected no read", cyc,
                         dut.rd_data_q);
            end else begin
                check("rd_data", dut.rd_data_q, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rgb();
        return 32'({rdata, gdata, bdata});
    endfunction

    initial begin
        int r, m, r2;
        gpio_pin_in = 13'h0000;

        at_cyc(10);
        check("rst_pc", 32'(dut.u_top_core.u_top_fetch.program_counter), 32'h0);
        check("rst_gpio_out", 32'(gpio_pin_out), 32'h0);
        check("rst_hsync", 32'(hsync), 32'h1);
        check("rst_vsync", 32'(vsync), 32'h1);
        check("rst_rgb", rgb(), 32'h0);

        at_cyc(62);
        gpio_pin_in = 13'h0200;
        r = cyc + 3;
        push_reads();

        at_cyc(r - 1);
        check("pc_held", 32'(dut.u_top_core.u_top_fetch.program_counter), 32'h0);
        at_cyc(r);
        check("pc_start", 32'(dut.u_top_core.u_top_fetch.program_counter), 32'h1);
        at_cyc(r + 7);
        check("gpio_before_wr", 32'(gpio_pin_out), 32'h0);
        at_cyc(r + 8);
        check("gpio_wr_a5", 32'(gpio_pin_out), 32'hA5);
        at_cyc(r + 12);
        check("gpio_wr_5a", 32'(gpio_pin_out), 32'h5A);
        at_cyc(r + 20);
        gpio_pin_in = 13'h1234;
        at_cyc(r + 21);
        check("gpio_ignore_wr", 32'(gpio_pin_out), 32'h5A);
        at_cyc(r + 42);
        check("gpio_wr_back", 32'(gpio_pin_out), 32'h34);

        at_cyc(r + 427);
        check("bar1_h85", rgb(), VgaEn ? 32'h00F : 32'h0);
        at_cyc(r + 1502);
        check("bar3_h300", rgb(), VgaEn ? 32'h0FF : 32'h0);
        at_cyc(r + 2502);
        check("color_h500", rgb(), VgaEn ? 32'hF80 : 32'h0);
        at_cyc(r + 3279);
        check("hsync_pre", 32'(hsync), 32'h1);
        at_cyc(r + 3280);
        check("hsync_fall", 32'(hsync), VgaEn ? 32'h0 : 32'h1);
        at_cyc(r + 3502);
        check("blank_h700", rgb(), 32'h0);
        check("hsync_mid", 32'(hsync), VgaEn ? 32'h0 : 32'h1);
        at_cyc(r + 3759);
        check("hsync_last_low", 32'(hsync), VgaEn ? 32'h0 : 32'h1);
        at_cyc(r + 3760);
        check("hsync_rise", 32'(hsync), 32'h1);
        at_cyc(r + 4051);
        check("color_line1", rgb(), VgaEn ? 32'hF80 : 32'h0);
        check("vsync_line1", 32'(vsync), 32'h1);
        at_cyc(r + 7279);
        check("hsync2_pre", 32'(hsync), 32'h1);
        at_cyc(r + 7280);
        check("hsync2_fall", 32'(hsync), VgaEn ? 32'h0 : 32'h1);

        m = r + 8000;
        at_cyc(m);
        gpio_pin_in = 13'h1034;
        at_cyc(m + 3);
        check("mid_rst_gpio", 32'(gpio_pin_out), 32'h0);
        check("mid_rst_hsync", 32'(hsync), 32'h1);
        check("mid_rst_vsync", 32'(vsync), 32'h1);
        check("mid_rst_rgb", rgb(), 32'h0);
        check("mid_rst_pc", 32'(dut.u_top_core.u_top_fetch.program_counter), 32'h0);
        gpio_pin_in = 13'h1234;
        r2 = cyc + 3;
        push_reads();

        at_cyc(r2 - 1);
        check("pc2_held", 32'(dut.u_top_core.u_top_fetch.program_counter), 32'h0);
        at_cyc(r2);
        check("pc2_start", 32'(dut.u_top_core.u_top_fetch.program_counter), 32'h1);
        at_cyc(r2 + 8);
        check("gpio2_wr_a5", 32'(gpio_pin_out), 32'hA5);
        at_cyc(r2 + 427);
        check("bar1_h85_run2", rgb(), VgaEn ? 32'h00F : 32'h0);
        at_cyc(r2 + 3279);
        check("hsync3_pre", 32'(hsync), 32'h1);
        at_cyc(r2 + 3280);
        check("hsync3_fall", 32'(hsync), VgaEn ? 32'h0 : 32'h1);

        at_cyc(r2 + 3300);
        check("reads_outstanding", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/zedboard_top.md
Name: zedboard_top

Overview:
- ZedBoard FPGA top level for the RockWave RISC-V system.
- Instantiates the existing core as u_top_core; its fetch stage exposes a 14-bit program_counter in u_top_fetch.
- Adds the board glue around the core: reset generation from a switch, a memory-mapped GPIO block, and a 640x480 VGA timing/colour generator.
- Runs from the board's 125 MHz oscillator.

Parameters:
- CLK_DIV, 5: system clocks per VGA pixel (125 MHz / 5 = 25 MHz pixel enable).
- GPIO_IN_W, 13: GPIO input width.
- GPIO_OUT_W, 8: GPIO output width.
- RST_BIT, 9: index of gpio_pin_in used as the reset switch.

Ports:
- clk  in  1  system clock, 125 MHz; all logic is in this single domain.
- gpio_pin_in  in  13  board switches/buttons; bit RST_BIT is the system reset switch (0 = reset).
- gpio_pin_out  out  8  LEDs.
- hsync  out  1  VGA horizontal sync, active low.
- vsync  out  1  VGA vertical sync, active low.
- rdata  out  4  VGA red.
- gdata  out  4  VGA green.
- bdata  out  4  VGA blue.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst_n is synchronous and active-low.
- rst_n generation: gpio_pin_in[RST_BIT] passes through a 2-flop synchronizer; its output is rst_n. Deassertion takes effect 2 clk after the pin rises.
- rst_n drives u_top_core and every register in this block.
- Re-lowering the pin at any time resets the whole system within 2 clk; no state is held.
- Input sampling: all gpio_pin_in bits pass through the same 2-flop synchronizer and are zero-extended to 32 bits on read.
- Core data bus: dmem_addr[31:0], dmem_wdata[31:0], dmem_we, dmem_re, dmem_rdata[31:0]. Addresses at or above 0xF000_0000 are decoded here; all other addresses stay inside the core.
- Register map:
  - 0xF000_0000 GPIO_OUT, RW, bits[7:0], reset 0x00. Drives gpio_pin_out directly from the register.
  - 0xF000_0004 GPIO_IN, RO, synchronized inputs.
  - 0xF000_0008 VGA_CTRL, RW, bit0 = test pattern select, reset 0.
  - 0xF000_000C VGA_COLOR, RW, bits[11:0] = {r,g,b}, reset 0x000.
- Bus rules:
  - Unmapped peripheral reads return 0; unmapped writes are ignored.
  - Read data is registered, valid 1 clk after dmem_re.
  - Writes take effect on the clk edge where dmem_we=1.
  - A simultaneous read and write to the same address returns the old value.
- Pixel enable: a divider counts 0..CLK_DIV-1 and asserts pix_en for 1 clk when the count is CLK_DIV-1. It resets to 0.
- Horizontal timing: hcount 0..799, advancing on pix_en.
  - Visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: vcount 0..524, increments when hcount wraps from 799 to 0.
  - Visible 0..479, sync 490..491.
- Sync outputs: hsync low when hcount is in 656..751; vsync low when vcount is in 490..491.
- Colour, active region (hcount<640 and vcount<480):
  - VGA_CTRL[0]=1: 8 colour bars, 80 px wide. Bar index i = hcount/80; r = {4{i[2]}}, g = {4{i[1]}}, b = {4{i[0]}}.
  - VGA_CTRL[0]=0: {rdata,gdata,bdata} = VGA_COLOR.
  - Outside the active region, rgb = 0.
- All VGA outputs are registered, 1 clk after the counter state.
- Reset values: hsync=1, vsync=1, rgb=0, hcount=vcount=0, gpio_pin_out=0.
- Timing summary: line = 4000 clk (32 us); hsync low 480 clk; frame = 2,100,000 clk.

Optional Feature:
- Macro ZEDBOARD_VGA_EN.
- Defined: the VGA divider, counters, colour logic and VGA registers are built as described.
- Undefined:
  - hsync=vsync=1 and rgb=0 constantly.
  - VGA_CTRL and VGA_COLOR read 0 and ignore writes.
  - GPIO and the core are unaffected.

Decomposition:
- Package zedboard_pkg holds:
  - peripheral base address and register offsets;
  - VGA timing constants (H/V visible, front porch, sync, back porch, totals);
  - GPIO widths.
- One natural sub-module: vga_timing (pixel divider, hcount/vcount, sync and active flags).
- Register decode and the colour mux stay in the top.

Test Plan:
- Hold gpio_pin_in=0x0000 for 500 ns, then 0x0200 → core held in reset, pc=0 during the low phase. pc starts advancing 2–3 clk after the rise; gpio_pin_out stays 0x00 until written.
- Core stores 0xA5 to 0xF000_0000 → gpio_pin_out=0xA5 on the next clk; a load from the same address returns 0x000000A5.
- With switches 0x1234 (bit9 set), a load from 0xF000_0004 returns 0x00001234.
- After reset release, observe syncs:
  - hsync falls 656*5 clk after line start and stays low exactly 480 clk;
  - the hsync period is 4000 clk;
  - vsync is low for 2 lines (8000 clk).
- Write VGA_CTRL=1 → pixel hcount=85 in an active line gives rgb=0x0,0x0,0xF (bar 1). Write VGA_CTRL=0 and VGA_COLOR=0xF80 → active pixels show r=F, g=8, b=0; blanking pixels show 0.
- Drive gpio_pin_in[9] low mid-frame for 3 clk → within 2 clk: hsync=vsync=1, rgb=0, gpio_pin_out=0, and counters restart from 0 after release.
